// File: rtl/modexp_engine.sv
// Modular exponentiation engine: RESULT = M^E mod N, right-to-left square-and-multiply with bit-serial interleaved modular multiply.
// Latency: DONE rises 1 + k*(BITS+1) + w*BITS edges after the GO edge (k exponent bits processed, w ones among them).
// Backpressure: none; LOAD/GO are ignored while BUSY, and DONE/RESULT hold in FIN until the next LOAD.
// Optional: define MODEXP_EARLY_EXIT_EN to stop as soon as the remaining exponent bits are all zero.
module modexp_engine #(
  parameter int BITS = 128
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            LOAD,
  input  logic            GO,
  input  logic [BITS-1:0] M,
  input  logic [BITS-1:0] E,
  input  logic [BITS-1:0] N,
  output logic [BITS-1:0] RESULT,
  output logic            DONE,
  output logic            BUSY
);

  localparam int PW = BITS + 2;          // multiply accumulator width, holds < 3N
  localparam int CW = $clog2(BITS + 1);  // exponent bit counter, counts up to BITS
  localparam int IW = $clog2(BITS);      // multiplier bit index, BITS-1 down to 0

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_MUL,
    S_SQR,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t          r_state;
  logic [BITS-1:0] r_m;
  logic [BITS-1:0] r_e;
  logic [BITS-1:0] r_n;
  logic [BITS-1:0] r_r;
  logic [BITS-1:0] r_b;
  logic [PW-1:0]   r_p;
  logic [BITS-1:0] r_ereg;
  logic [CW-1:0]   r_bitcnt;
  logic [IW-1:0]   r_idx;
  logic [BITS-1:0] r_result;
  logic            r_done;
  logic            r_busy;

  logic [BITS-1:0] w_a;
  logic            w_abit;
  logic [PW-1:0]   w_n_ext;
  logic [PW-1:0]   w_p2;
  logic [PW-1:0]   w_s1;
  logic [PW-1:0]   w_p_red;
  logic [BITS-1:0] w_e_shift;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_term;

  // One interleaved multiply step: MUL multiplies R by B, SQR multiplies B by B.
  // The multiplier is scanned MSB first; P stays below N after each step, so
  // 2P + B < 3N fits in BITS+2 bits and at most two subtractions are needed.
  always_comb begin
    w_a     = (r_state == S_MUL) ? r_r : r_b;
    w_abit  = w_a[r_idx];
    w_n_ext = {2'b00, r_n};
    w_p2    = (r_p << 1) + (w_abit ? {2'b00, r_b} : {PW{1'b0}});
    w_s1    = (w_p2 >= w_n_ext) ? (w_p2 - w_n_ext) : w_p2;
    w_p_red = (w_s1 >= w_n_ext) ? (w_s1 - w_n_ext) : w_s1;
  end

  assign w_e_shift = r_ereg >> 1;
  assign w_cnt_inc = r_bitcnt + 1'b1;

`ifdef MODEXP_EARLY_EXIT_EN
  // Stop after the last exponent bit or once no set bits remain; skipped
  // iterations would only square B and leave R unchanged.
  assign w_term = (w_cnt_inc == CW'(BITS)) || (w_e_shift == '0);
`else
  // Always walk every exponent bit, giving data-independent iteration count.
  assign w_term = (w_cnt_inc == CW'(BITS));
`endif

  // Control FSM and datapath registers, all outputs registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_m      <= '0;
      r_e      <= '0;
      r_n      <= '0;
      r_r      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_ereg   <= '0;
      r_bitcnt <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (LOAD) begin
            r_m <= M;
            r_e <= E;
            r_n <= N;
          end else if (GO) begin
            r_state <= S_SETUP;
            r_busy  <= 1'b1;
          end
        end
        S_SETUP: begin
          r_r      <= BITS'(1);
          r_b      <= r_m;
          r_ereg   <= r_e;
          r_bitcnt <= '0;
          r_p      <= '0;
          r_idx    <= IW'(BITS - 1);
          r_state  <= r_e[0] ? S_MUL : S_SQR;
        end
        S_MUL: begin
          if (r_idx == '0) begin
            r_r     <= w_p_red[BITS-1:0];
            r_p     <= '0;
            r_idx   <= IW'(BITS - 1);
            r_state <= S_SQR;
          end else begin
            r_p   <= w_p_red;
            r_idx <= r_idx - 1'b1;
          end
        end
        S_SQR: begin
          if (r_idx == '0) begin
            r_b     <= w_p_red[BITS-1:0];
            r_p     <= '0;
            r_idx   <= IW'(BITS - 1);
            r_state <= S_SHIFT;
          end else begin
            r_p   <= w_p_red;
            r_idx <= r_idx - 1'b1;
          end
        end
        S_SHIFT: begin
          r_ereg   <= w_e_shift;
          r_bitcnt <= w_cnt_inc;
          if (w_term) begin
            r_result <= r_r;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_FIN;
          end else begin
            r_state <= w_e_shift[0] ? S_MUL : S_SQR;
          end
        end
        S_FIN: begin
          // GO is deliberately ignored here; only LOAD leaves FIN.
          if (LOAD) begin
            r_m     <= M;
            r_e     <= E;
            r_n     <= N;
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign RESULT = r_result;
  assign DONE   = r_done;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_modexp_engine.sv
// Bench for modexp_engine at BITS=16: directed scenarios plus random operands,
// checked by a queue scoreboard against an arithmetic modexp and latency model.
// Build with or without MODEXP_EARLY_EXIT_EN; the latency model follows the same macro.
module tb_modexp_engine;

  localparam int BITS = 16;

  logic            clk;
  logic            rst;
  logic            load;
  logic            go;
  logic [BITS-1:0] m_in;
  logic [BITS-1:0] e_in;
  logic [BITS-1:0] n_in;
  logic [BITS-1:0] result;
  logic            done;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [BITS-1:0] res;
    int              edge_no;
    string           tag;
  } exp_t;

  exp_t sb[$];

  modexp_engine #(.BITS(BITS)) dut (
    .CLK    (clk),
    .RESET  (rst),
    .LOAD   (load),
    .GO     (go),
    .M      (m_in),
    .E      (e_in),
    .N      (n_in),
    .RESULT (result),
    .DONE   (done),
    .BUSY   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Plain square-and-multiply on integers.
  function automatic logic [BITS-1:0] ref_modexp(input longint m, input longint e, input longint n);
    longint r;
    longint b;
    longint x;
    r = 1;
    b = m % n;
    x = e;
    while (x > 0) begin
      if (x % 2 == 1) r = (r * b) % n;
      b = (b * b) % n;
      x = x / 2;
    end
    return BITS'(r);
  endfunction

  // Edges from GO to DONE: one setup cycle, each processed bit costs a squaring
  // plus a shift, and each processed one bit adds a multiply.
  function automatic int ref_latency(input logic [BITS-1:0] e);
    int k;
    int w;
    w = $countones(e);
`ifdef MODEXP_EARLY_EXIT_EN
    k = 1;
    for (int i = 0; i < BITS; i++) if (e[i]) k = i + 1;
`else
    k = BITS;
`endif
    return 1 + k * (BITS + 1) + w * BITS;
  endfunction

  task automatic do_load(input logic [BITS-1:0] m, input logic [BITS-1:0] e, input logic [BITS-1:0] n);
    @(negedge clk);
    m_in = m;
    e_in = e;
    n_in = n;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called at a negedge; the following posedge is the GO-sampling edge.
  task automatic do_go(input logic [BITS-1:0] m, input logic [BITS-1:0] e, input logic [BITS-1:0] n,
                       input bit expect_done, input string tag);
    exp_t it;
    go = 1'b1;
    if (expect_done) begin
      it.res     = ref_modexp(longint'(m), longint'(e), longint'(n));
      it.edge_no = cyc + 1 + ref_latency(e);
      it.tag     = tag;
      sb.push_back(it);
    end
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, longint'(done), 1);
  endtask

  task automatic run_op(input logic [BITS-1:0] m, input logic [BITS-1:0] e, input logic [BITS-1:0] n,
                        input string tag);
    do_load(m, e, n);
    do_go(m, e, n, 1'b1, tag);
    wait_done(tag);
  endtask

  // Monitor: on every rising DONE, pop the oldest expectation and compare.
  initial begin
    logic prev;
    exp_t it;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          it = sb.pop_front();
          chk({it.tag, "_result"}, longint'(result), longint'(it.res));
          chk({it.tag, "_done_edge"}, longint'(cyc), longint'(it.edge_no));
          chk({it.tag, "_busy_at_done"}, longint'(busy), 0);
        end
      end
      prev = done;
    end
  end

  initial begin
    logic [BITS-1:0] rn;
    logic [BITS-1:0] rm;
    logic [BITS-1:0] re;

    rst  = 1'b1;
    load = 1'b0;
    go   = 1'b0;
    m_in = '0;
    e_in = '0;
    n_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_result", longint'(result), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_busy", longint'(busy), 0);

    // Known answers, including the forward/inverse RSA pair on N=29*41.
    run_op(16'h01CE, 16'd3, 16'd1189, "m462_e3");
    chk("m462_e3_const", longint'(result), 224);
    run_op(16'd224, 16'd187, 16'd1189, "m224_e187");
    chk("m224_e187_const", longint'(result), 16'h01CE);

    // GO held while finished must not restart.
    @(negedge clk);
    go = 1'b1;
    repeat (6) @(negedge clk);
    chk("fin_go_done_held", longint'(done), 1);
    chk("fin_go_not_busy", longint'(busy), 0);
    chk("fin_go_result_held", longint'(result), 16'h01CE);
    go = 1'b0;

    run_op(16'h01CE, 16'd0, 16'd1189, "e_zero");
    chk("e_zero_const", longint'(result), 1);
    run_op(16'd0, 16'd3, 16'd1189, "m_zero");
    chk("m_zero_const", longint'(result), 0);
    run_op(16'd7, 16'hFFFF, 16'd1189, "e_all_ones");

    // Reset in the squaring phase of the second exponent bit.
    run_op(16'd5, 16'd3, 16'd1189, "pre_reset");
    do_load(16'h01CE, 16'd3, 16'd1189);
    do_go(16'h01CE, 16'd3, 16'd1189, 1'b0, "aborted");
    repeat (55) @(negedge clk);
    chk("busy_before_reset", longint'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_reset_busy", longint'(busy), 0);
    chk("midrun_reset_done", longint'(done), 0);
    chk("midrun_reset_result", longint'(result), 0);
    repeat (3) @(negedge clk);
    chk("idle_after_reset_busy", longint'(busy), 0);
    run_op(16'd100, 16'd77, 16'd1189, "after_reset");

    // LOAD while busy must be ignored; LOAD in FIN clears DONE next cycle.
    do_load(16'h01CE, 16'd3, 16'd1189);
    do_go(16'h01CE, 16'd3, 16'd1189, 1'b1, "load_while_busy");
    repeat (10) @(negedge clk);
    m_in = 16'd5;
    e_in = 16'd9;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done("load_while_busy");
    chk("load_while_busy_const", longint'(result), 224);
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("fin_load_clears_done", longint'(done), 0);
    chk("fin_load_keeps_result", longint'(result), 224);

    // Random operands with M < N, N >= 2.
    for (int i = 0; i < 150; i++) begin
      if (i % 3 == 0) rn = 16'd1189;
      else rn = BITS'($urandom_range(2, 65535));
      rm = BITS'($urandom_range(0, int'(rn) - 1));
      re = BITS'($urandom);
      if (i % 5 == 1) re = re & 16'h00FF;
      run_op(rm, re, rn, "rand");
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", longint'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
